// File: rtl/ysyx_24110015_lsu_if.sv
`timescale 1ns/1ps
// ysyx_24110015_lsu_if
// Bundles the three handshake channels of the load/store unit:
//   upstream     : in_valid/in_ready plus in_addr, in_wdata, in_funct3,
//                  in_is_load, in_is_store (instruction from the ALU stage)
//   memory       : mem_req_valid/mem_req_ready plus mem_addr, mem_wen,
//                  mem_wdata, mem_wmask (request); mem_rsp_valid, mem_rdata
//                  (response or write acknowledge)
//   writeback    : out_valid/out_ready plus out_data, out_err
// Modport master is the LSU view; modport slave is the surrounding
// pipeline/memory view.
interface ysyx_24110015_lsu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic [2:0]            in_funct3;
  logic                  in_is_load;
  logic                  in_is_store;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_err;

  modport master (
    input  in_valid, in_addr, in_wdata, in_funct3, in_is_load, in_is_store,
    output in_ready,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output out_valid, out_data, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_funct3, in_is_load, in_is_store,
    input  in_ready,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  out_valid, out_data, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_24110015_lsu.sv
`timescale 1ns/1ps
// ysyx_24110015_lsu
// Load/store unit placed right after the ALU. The ALU result is either the
// effective address of a load/store or, for any other instruction, the value
// simply handed on to writeback. A memory access issues one word-aligned
// request, waits for the response, then aligns and extends the loaded data.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - ysyx_24110015_lsu_if.master: upstream, memory and writeback
//          valid/ready channels
// All outputs are registered; the FSM walks IDLE -> (REQ -> RESP ->) DONE.
module ysyx_24110015_lsu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_24110015_lsu_if.master         bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state;

  // Only what the load extraction needs survives past the accept cycle;
  // everything store-related is encoded straight into the request registers.
  logic [1:0] off_q;
  logic [2:0] funct3_q;
  logic       is_load_q;

  logic                  is_mem;
  logic                  funct3_ok;
  logic                  misaligned;
  logic                  acc_err;
  logic [3:0]            st_mask;
  logic [DATA_WIDTH-1:0] st_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_result;

  // Decode the incoming instruction: legality, alignment and store lanes.
  // funct3[1:0] gives the size (byte/half/word); funct3[2] marks unsigned
  // loads, which do not exist for stores.
  always_comb begin
    is_mem     = bus.in_is_load | bus.in_is_store;
    funct3_ok  = 1'b0;
    misaligned = 1'b0;
    st_mask    = 4'b0000;
    st_data    = bus.in_wdata;

    if (bus.in_is_load) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
        default: funct3_ok = 1'b0;
      endcase
    end else begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
        default: funct3_ok = 1'b0;
      endcase
    end

    case (bus.in_funct3[1:0])
      2'b01:   misaligned = bus.in_addr[0];
      2'b10:   misaligned = |bus.in_addr[1:0];
      default: misaligned = 1'b0;
    endcase

    // Store data is replicated across lanes so the memory can pick any
    // enabled byte without knowing the offset.
    case (bus.in_funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << bus.in_addr[1:0];
        st_data = {4{bus.in_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << bus.in_addr[1:0];
        st_data = {2{bus.in_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = bus.in_wdata;
      end
    endcase

    acc_err = (bus.in_is_load & bus.in_is_store) |
              (is_mem & (~funct3_ok | misaligned));
  end

  // Pick the addressed byte/halfword out of the returned word and extend it.
  always_comb begin
    ld_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_result = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_result = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_result = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_result = bus.mem_rdata;
    endcase
  end

  // Main FSM with registered outputs. Every state only changes outputs on its
  // own handshake, so a stall simply holds everything where it is. The DONE
  // handshake re-arms in_ready for the next cycle, never the same one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bus.in_ready      <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wen       <= 1'b0;
      bus.mem_wdata     <= '0;
      bus.mem_wmask     <= 4'b0000;
      bus.out_valid     <= 1'b0;
      bus.out_data      <= '0;
      bus.out_err       <= 1'b0;
      off_q             <= 2'b00;
      funct3_q          <= 3'b000;
      is_load_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            off_q        <= bus.in_addr[1:0];
            funct3_q     <= bus.in_funct3;
            is_load_q    <= bus.in_is_load;
            if (!is_mem) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.in_addr;
              bus.out_err   <= 1'b0;
            end else if (acc_err) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_data  <= '0;
              bus.out_err   <= 1'b1;
            end else begin
              state             <= REQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_addr      <= {bus.in_addr[DATA_WIDTH-1:2], 2'b00};
              bus.mem_wen       <= bus.in_is_store;
              bus.mem_wdata     <= bus.in_is_store ? st_data : '0;
              bus.mem_wmask     <= bus.in_is_store ? st_mask : 4'b0000;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state             <= RESP;
            bus.mem_req_valid <= 1'b0;
            bus.mem_wen       <= 1'b0;
            bus.mem_wmask     <= 4'b0000;
          end
        end
        RESP: begin
          if (bus.mem_rsp_valid) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_err   <= 1'b0;
            bus.out_data  <= is_load_q ? ld_result : '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
